// File: rtl/ex_stage_if.sv
`default_nettype none
// =============================================================================
// Module   : ex_stage_if
// Brief    : Operand, control and result bundle for the MIPS32 execute stage.
// Revision : 1.0 - initial release
// =============================================================================
interface ex_stage_if #(
    parameter int BUS_SIZE = 32
);
    logic                i_stall;
    logic                i_alu_src_A;
    logic [2:0]          i_alu_src_B;
    logic [1:0]          i_reg_dst;
    logic [2:0]          i_alu_opp;
    logic [1:0]          i_src_A_select;
    logic [1:0]          i_src_B_select;
    logic [4:0]          i_rt;
    logic [4:0]          i_rd;
    logic [5:0]          i_funct;
    logic [BUS_SIZE-1:0] i_forwarded_alu_result;
    logic [BUS_SIZE-1:0] i_forwarded_wb_result;
    logic [BUS_SIZE-1:0] i_bus_A;
    logic [BUS_SIZE-1:0] i_bus_B;
    logic [BUS_SIZE-1:0] i_shamt_ext_unsigned;
    logic [BUS_SIZE-1:0] i_inm_ext_signed;
    logic [BUS_SIZE-1:0] i_inm_upp;
    logic [BUS_SIZE-1:0] i_inm_ext_unsigned;
    logic [BUS_SIZE-1:0] i_next_seq_pc;
    logic [4:0]          o_wb_addr;
    logic [BUS_SIZE-1:0] o_alu_result;
    logic [BUS_SIZE-1:0] o_forwarded_data_A;
    logic [BUS_SIZE-1:0] o_forwarded_data_B;
    logic                o_overflow;

    modport master (
        output i_stall, i_alu_src_A, i_alu_src_B, i_reg_dst, i_alu_opp,
               i_src_A_select, i_src_B_select, i_rt, i_rd, i_funct,
               i_forwarded_alu_result, i_forwarded_wb_result, i_bus_A, i_bus_B,
               i_shamt_ext_unsigned, i_inm_ext_signed, i_inm_upp,
               i_inm_ext_unsigned, i_next_seq_pc,
        input  o_wb_addr, o_alu_result, o_forwarded_data_A, o_forwarded_data_B,
               o_overflow
    );

    modport slave (
        input  i_stall, i_alu_src_A, i_alu_src_B, i_reg_dst, i_alu_opp,
               i_src_A_select, i_src_B_select, i_rt, i_rd, i_funct,
               i_forwarded_alu_result, i_forwarded_wb_result, i_bus_A, i_bus_B,
               i_shamt_ext_unsigned, i_inm_ext_signed, i_inm_upp,
               i_inm_ext_unsigned, i_next_seq_pc,
        output o_wb_addr, o_alu_result, o_forwarded_data_A, o_forwarded_data_B,
               o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// =============================================================================
// Module   : ex_stage
// Brief    : MIPS32 execute stage with forwarding, ALU and EX/MEM registers.
//            Define EX_OVERFLOW_TRAP_EN to build the signed-overflow flag.
// Revision : 1.0 - initial release
// =============================================================================
module ex_stage #(
    parameter int BUS_SIZE           = 32,
    parameter int ALU_CTRL_BUS_WIDTH = 6
) (
    input  logic      i_clk,
    input  logic      i_reset,
    ex_stage_if.slave bus
);
    localparam int MSB = BUS_SIZE - 1;

    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SLL  = 6'b000000;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SRL  = 6'b000010;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SRA  = 6'b000011;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SLLV = 6'b000100;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SRLV = 6'b000110;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SRAV = 6'b000111;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_JALR = 6'b001001;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_ADD  = 6'b100000;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_ADDU = 6'b100001;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SUB  = 6'b100010;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SUBU = 6'b100011;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_AND  = 6'b100100;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_OR   = 6'b100101;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_XOR  = 6'b100110;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_NOR  = 6'b100111;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SLT  = 6'b101010;
    localparam logic [ALU_CTRL_BUS_WIDTH-1:0] c_FN_SLTU = 6'b101011;

    logic [BUS_SIZE-1:0]           w_fwd_a;
    logic [BUS_SIZE-1:0]           w_fwd_b;
    logic [BUS_SIZE-1:0]           w_op_a;
    logic [BUS_SIZE-1:0]           w_op_b;
    logic [BUS_SIZE-1:0]           w_sum;
    logic [BUS_SIZE-1:0]           w_diff;
    logic [BUS_SIZE-1:0]           w_alu_out;
    logic [4:0]                    w_shamt;
    logic [4:0]                    w_wb_addr;
    logic [ALU_CTRL_BUS_WIDTH-1:0] w_alu_ctrl;

    logic [4:0]                    r_wb_addr;
    logic [BUS_SIZE-1:0]           r_alu_result;
    logic [BUS_SIZE-1:0]           r_fwd_a;
    logic [BUS_SIZE-1:0]           r_fwd_b;

    always_comb begin
        case (bus.i_src_A_select)
            2'b00:   w_fwd_a = bus.i_forwarded_alu_result;
            2'b01:   w_fwd_a = bus.i_forwarded_wb_result;
            default: w_fwd_a = bus.i_bus_A;
        endcase
        case (bus.i_src_B_select)
            2'b00:   w_fwd_b = bus.i_forwarded_alu_result;
            2'b01:   w_fwd_b = bus.i_forwarded_wb_result;
            default: w_fwd_b = bus.i_bus_B;
        endcase
    end

    always_comb begin
        w_op_a = bus.i_alu_src_A ? bus.i_shamt_ext_unsigned : w_fwd_a;
        case (bus.i_alu_src_B)
            3'b000:  w_op_b = w_fwd_b;
            3'b001:  w_op_b = bus.i_inm_ext_unsigned;
            3'b010:  w_op_b = bus.i_inm_ext_signed;
            3'b011:  w_op_b = bus.i_inm_upp;
            3'b100:  w_op_b = bus.i_next_seq_pc;
            default: w_op_b = '0;
        endcase
        case (bus.i_reg_dst)
            2'b00:   w_wb_addr = 5'd31;
            2'b01:   w_wb_addr = bus.i_rd;
            2'b10:   w_wb_addr = bus.i_rt;
            default: w_wb_addr = 5'd0;
        endcase
    end

    // Immediate ops reuse the R-type funct encoding so one ALU decode serves both.
    always_comb begin
        case (bus.i_alu_opp)
            3'b000:  w_alu_ctrl = c_FN_ADD;
            3'b001:  w_alu_ctrl = c_FN_AND;
            3'b010:  w_alu_ctrl = c_FN_OR;
            3'b011:  w_alu_ctrl = c_FN_XOR;
            3'b100:  w_alu_ctrl = c_FN_SLT;
            3'b101:  w_alu_ctrl = c_FN_JALR;
            3'b110:  w_alu_ctrl = bus.i_funct;
            default: w_alu_ctrl = c_FN_SUB;
        endcase
    end

    assign w_shamt = w_op_a[4:0];
    assign w_sum   = w_op_a + w_op_b;
    assign w_diff  = w_op_a - w_op_b;

    always_comb begin
        w_alu_out = '0;
        case (w_alu_ctrl)
            c_FN_SLL, c_FN_SLLV: w_alu_out = w_op_b << w_shamt;
            c_FN_SRL, c_FN_SRLV: w_alu_out = w_op_b >> w_shamt;
            c_FN_SRA, c_FN_SRAV: w_alu_out = $signed(w_op_b) >>> w_shamt;
            c_FN_ADD, c_FN_ADDU: w_alu_out = w_sum;
            c_FN_SUB, c_FN_SUBU: w_alu_out = w_diff;
            c_FN_AND:            w_alu_out = w_op_a & w_op_b;
            c_FN_OR:             w_alu_out = w_op_a | w_op_b;
            c_FN_XOR:            w_alu_out = w_op_a ^ w_op_b;
            c_FN_NOR:            w_alu_out = ~(w_op_a | w_op_b);
            c_FN_SLT:            w_alu_out = {{(BUS_SIZE-1){1'b0}},
                                              ($signed(w_op_a) < $signed(w_op_b))};
            c_FN_SLTU:           w_alu_out = {{(BUS_SIZE-1){1'b0}}, (w_op_a < w_op_b)};
            c_FN_JALR:           w_alu_out = w_op_b;
            default:             w_alu_out = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wb_addr    <= '0;
            r_alu_result <= '0;
            r_fwd_a      <= '0;
            r_fwd_b      <= '0;
        end else if (!bus.i_stall) begin
            r_wb_addr    <= w_wb_addr;
            r_alu_result <= w_alu_out;
            r_fwd_a      <= w_fwd_a;
            r_fwd_b      <= w_fwd_b;
        end
    end

    assign bus.o_wb_addr          = r_wb_addr;
    assign bus.o_alu_result       = r_alu_result;
    assign bus.o_forwarded_data_A = r_fwd_a;
    assign bus.o_forwarded_data_B = r_fwd_b;

`ifdef EX_OVERFLOW_TRAP_EN
    logic w_overflow;
    logic r_overflow;

    // Only the trapping ADD/SUB encodings flag; ADDU/SUBU wrap silently.
    always_comb begin
        w_overflow = 1'b0;
        if (w_alu_ctrl == c_FN_ADD) begin
            w_overflow = (w_op_a[MSB] == w_op_b[MSB]) && (w_sum[MSB] != w_op_a[MSB]);
        end else if (w_alu_ctrl == c_FN_SUB) begin
            w_overflow = (w_op_a[MSB] != w_op_b[MSB]) && (w_diff[MSB] != w_op_a[MSB]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (!bus.i_stall) begin
            r_overflow <= w_overflow;
        end
    end

    assign bus.o_overflow = r_overflow;
`else
    assign bus.o_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_ex_stage
// Brief    : Scoreboard bench for ex_stage; expected overflow follows
//            EX_OVERFLOW_TRAP_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ex_stage;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    typedef struct packed {
        logic [4:0]  wb;
        logic [31:0] res;
        logic [31:0] fa;
        logic [31:0] fb;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    ex_stage_if #(.BUS_SIZE(32)) bus ();

    ex_stage #(.BUS_SIZE(32), .ALU_CTRL_BUS_WIDTH(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ov_en(input logic v);
`ifdef EX_OVERFLOW_TRAP_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic exp_t mk(input logic [4:0] wb, input logic [31:0] res,
                                input logic [31:0] fa, input logic [31:0] fb,
                                input logic ov);
        exp_t e;
        e.wb = wb; e.res = res; e.fa = fa; e.fb = fb; e.ov = ov_en(ov);
        return e;
    endfunction

    // Reference for R-type ops, written directly from the MIPS definitions.
    function automatic logic [31:0] ref_r(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned s;
        s = a[4:0];
        case (f)
            6'h00, 6'h04: return b << s;
            6'h02, 6'h06: return b >> s;
            6'h03, 6'h07: return 32'($signed(b) >>> s);
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h26:        return a ^ b;
            6'h27:        return ~(a | b);
            6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B:        return (a < b) ? 32'd1 : 32'd0;
            6'h09:        return b;
            default:      return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ov(input logic [5:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
        longint r;
        if (f == 6'h20)      r = longint'($signed(a)) + longint'($signed(b));
        else if (f == 6'h22) r = longint'($signed(a)) - longint'($signed(b));
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic idle();
        rst = 1'b0;
        bus.i_stall = 1'b0;            bus.i_alu_src_A = 1'b0;
        bus.i_alu_src_B = 3'b000;      bus.i_reg_dst = 2'b10;
        bus.i_alu_opp = 3'b110;        bus.i_src_A_select = 2'b10;
        bus.i_src_B_select = 2'b10;    bus.i_rt = 5'd0;  bus.i_rd = 5'd0;
        bus.i_funct = 6'b100001;       bus.i_forwarded_alu_result = '0;
        bus.i_forwarded_wb_result = '0; bus.i_bus_A = '0; bus.i_bus_B = '0;
        bus.i_shamt_ext_unsigned = '0; bus.i_inm_ext_signed = '0;
        bus.i_inm_upp = '0;            bus.i_inm_ext_unsigned = '0;
        bus.i_next_seq_pc = '0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rt);
        idle();
        bus.i_funct = f; bus.i_bus_A = a; bus.i_bus_B = b; bus.i_rt = rt;
    endtask

    // Inputs are set at the falling edge; the result appears after the next rising edge.
    task automatic cycle(input string tag, input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".wb"},  {27'd0, bus.o_wb_addr}, {27'd0, x.wb});
        chk({tag, ".res"}, bus.o_alu_result,       x.res);
        chk({tag, ".fa"},  bus.o_forwarded_data_A, x.fa);
        chk({tag, ".fb"},  bus.o_forwarded_data_B, x.fb);
        chk({tag, ".ov"},  {31'd0, bus.o_overflow}, {31'd0, x.ov});
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  fl [16];
        logic [31:0] a, b;
        logic [4:0]  rt;
        fl = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        n_total = 0;
        n_bad   = 0;
        idle();
        @(negedge clk);

        rtype(6'h20, 32'hDEADBEEF, 32'h0BADF00D, 5'd9);
        rst = 1'b1;
        cycle("reset", mk(5'd0, 32'd0, 32'd0, 32'd0, 1'b0));
        rtype(6'h20, 32'hDEADBEEF, 32'h0BADF00D, 5'd9);
        bus.i_stall = 1'b1;
        cycle("post_reset_stall", mk(5'd0, 32'd0, 32'd0, 32'd0, 1'b0));

        rtype(6'h20, 32'h12345678, 32'h87654321, 5'd10);
        cycle("add", mk(5'd10, 32'h99999999, 32'h12345678, 32'h87654321, 1'b0));

        idle();
        bus.i_alu_src_A = 1'b1;        bus.i_shamt_ext_unsigned = 32'd3;
        bus.i_alu_src_B = 3'b010;      bus.i_inm_ext_signed = 32'h0000ABCD;
        bus.i_alu_opp = 3'b000;        bus.i_reg_dst = 2'b01;  bus.i_rd = 5'd15;
        bus.i_src_A_select = 2'b01;    bus.i_src_B_select = 2'b01;
        bus.i_forwarded_wb_result = 32'h5B5B5B5B;
        cycle("addi", mk(5'd15, 32'h0000ABD0, 32'h5B5B5B5B, 32'h5B5B5B5B, 1'b0));

        rtype(6'h03, 32'hFFFFFFE4, 32'h80000000, 5'd7);
        cycle("sra", mk(5'd7, 32'hF8000000, 32'hFFFFFFE4, 32'h80000000, 1'b0));
        rtype(6'h2B, 32'hFFFFFFFF, 32'h00000001, 5'd3);
        cycle("sltu", mk(5'd3, 32'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0));
        rtype(6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd3);
        cycle("slt", mk(5'd3, 32'd1, 32'hFFFFFFFF, 32'h00000001, 1'b0));

        idle();
        bus.i_alu_opp = 3'b101;        bus.i_alu_src_B = 3'b100;
        bus.i_next_seq_pc = 32'h00000008; bus.i_reg_dst = 2'b00;
        bus.i_funct = 6'bxxxxxx;
        bus.i_src_A_select = 2'b00;    bus.i_src_B_select = 2'b00;
        bus.i_forwarded_alu_result = 32'hCAFEF00D;
        cycle("link", mk(5'd31, 32'h00000008, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0));

        idle();
        bus.i_alu_opp = 3'b111; bus.i_bus_A = 32'd100; bus.i_bus_B = 32'd30;
        bus.i_reg_dst = 2'b11;  bus.i_rd = 5'd21;
        cycle("subop", mk(5'd0, 32'd70, 32'd100, 32'd30, 1'b0));
        rtype(6'h25, 32'h11111111, 32'h22222222, 5'd5);
        bus.i_stall = 1'b1;
        cycle("stall_hold", mk(5'd0, 32'd70, 32'd100, 32'd30, 1'b0));

        rtype(6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd4);
        cycle("add_ovf", mk(5'd4, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1));
        rtype(6'h21, 32'h12121212, 32'h34343434, 5'd6);
        bus.i_stall = 1'b1;
        cycle("ovf_hold", mk(5'd4, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1));
        rtype(6'h21, 32'h7FFFFFFF, 32'h00000001, 5'd4);
        cycle("addu", mk(5'd4, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0));
        rtype(6'h22, 32'h80000000, 32'h00000001, 5'd8);
        cycle("sub_ovf", mk(5'd8, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b1));
        rtype(6'h23, 32'h80000000, 32'h00000001, 5'd8);
        cycle("subu", mk(5'd8, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b0));

        idle();
        bus.i_alu_opp = 3'b000; bus.i_alu_src_B = 3'b001;
        bus.i_inm_ext_unsigned = 32'd1; bus.i_bus_A = 32'h7FFFFFFF; bus.i_rt = 5'd2;
        cycle("addi_ovf", mk(5'd2, 32'h80000000, 32'h7FFFFFFF, 32'd0, 1'b1));
        idle();
        bus.i_alu_opp = 3'b111; bus.i_bus_A = 32'h80000000; bus.i_bus_B = 32'd1;
        bus.i_rt = 5'd2;
        cycle("subop_ovf", mk(5'd2, 32'h7FFFFFFF, 32'h80000000, 32'd1, 1'b1));

        rtype(6'h27, 32'hF0F0F0F0, 32'h0000FFFF, 5'd12);
        cycle("nor", mk(5'd12, 32'h0F0F0000, 32'hF0F0F0F0, 32'h0000FFFF, 1'b0));
        rtype(6'h3F, 32'h12345678, 32'h9ABCDEF0, 5'd13);
        cycle("bad_funct", mk(5'd13, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0));

        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            b  = $urandom;
            rt = 5'($urandom_range(31));
            if (i % 3 == 0) a = {a[31], 31'h7FFFFFF0 | a[3:0]};
            rtype(fl[i % 16], a, b, rt);
            cycle("rand", mk(rt, ref_r(fl[i % 16], a, b), a, b, ref_ov(fl[i % 16], a, b)));
        end

        rtype(6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd30);
        rst = 1'b1;
        bus.i_stall = 1'b1;
        cycle("reset_over_stall", mk(5'd0, 32'd0, 32'd0, 32'd0, 1'b0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline.
- Resolves forwarding for operands A/B, selects ALU sources and decodes ALU control from the ID control code plus funct. Computes the result and selects the write-back register address.
- All outputs are registered, so the block also acts as the EX/MEM boundary register.

Parameters:
- BUS_SIZE, 32, datapath width.
- ALU_CTRL_BUS_WIDTH, 6, width of the internal ALU control code; equals funct width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  1 = hold all output registers.
- i_alu_src_A  in  1  0 = forwarded A, 1 = i_shamt_ext_unsigned.
- i_alu_src_B  in  3  000 forwarded B; 001 i_inm_ext_unsigned; 010 i_inm_ext_signed; 011 i_inm_upp; 100 i_next_seq_pc; others 0.
- i_reg_dst  in  2  00 = 5'd31; 01 = i_rd; 10 = i_rt; 11 = 5'd0.
- i_alu_opp  in  3  opcode class from ID.
- i_src_A_select, i_src_B_select  in  2 each  00 i_forwarded_alu_result; 01 i_forwarded_wb_result; 10/11 i_bus_A / i_bus_B.
- i_rt, i_rd  in  5  register specifiers.
- i_funct  in  6  R-type funct.
- i_forwarded_alu_result, i_forwarded_wb_result  in  BUS_SIZE  forwarding sources (EX/MEM, MEM/WB).
- i_bus_A, i_bus_B  in  BUS_SIZE  register-file reads.
- i_shamt_ext_unsigned, i_inm_ext_signed, i_inm_upp, i_inm_ext_unsigned, i_next_seq_pc  in  BUS_SIZE  operand sources.
- o_wb_addr  out  5  registered destination register.
- o_alu_result  out  BUS_SIZE  registered ALU result.
- o_forwarded_data_A, o_forwarded_data_B  out  BUS_SIZE  registered forwarded operands; B is the store data.
- o_overflow  out  1  see Optional Feature.

Behaviour:
- Datapath: combinational forwarding mux, then ALU-source mux, then ALU. Results are captured on the rising edge of i_clk, giving 1-cycle latency.
- Priority per edge: i_reset > i_stall > load.
- Reset clears every output to 0.
- Stall holds every output.
- ALU operand A = alu_src_A ? shamt_ext_unsigned : fwdA. Operand B is chosen per i_alu_src_B.
- ALU control from i_alu_opp:
  - 000 ADD
  - 001 AND
  - 010 OR
  - 011 XOR
  - 100 SLT (signed)
  - 101 pass B (LUI, link)
  - 110 R-type: use i_funct
  - 111 SUB
- Funct codes:
  - 000000 SLL, 000010 SRL, 000011 SRA: B shifted by A[4:0]
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: B shifted by A[4:0]
  - 100000/100001 ADD/ADDU
  - 100010/100011 SUB/SUBU
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 001001 JALR: pass B
  - any other funct: result 0
- Arithmetic:
  - Modulo 2^BUS_SIZE; no traps.
  - SLT/SLTU produce 1 or 0, zero-extended.
  - SRA replicates B[MSB].
  - Shift amount uses only A[4:0].
- Forwarding: o_forwarded_data_A/B register the forwarding-mux outputs, not the ALU operands.
- X on unused inputs (e.g. i_funct when i_alu_opp != 110) must not affect the result.

Optional Feature:
- Macro EX_OVERFLOW_TRAP_EN.
- When defined: o_overflow registers signed overflow of ADD (funct 100000), SUB (funct 100010), ALU op 000 and ALU op 111. Overflow = operand signs equal (for SUB, A sign differs from B sign) and result sign differs from A. o_overflow is 0 on reset, held on stall, and not set by ADDU/SUBU.
- When undefined: o_overflow is constant 0 and no overflow logic is built.

Test Plan:
- Reset: assert i_reset for one edge with arbitrary inputs -> all outputs 0. Deassert with i_stall=1 -> outputs remain 0.
- R-type ADD: src selects 10/10, alu_src_A=0, alu_src_B=000, alu_opp=110, funct=100000, bus_A=0x12345678, bus_B=0x87654321, reg_dst=10, rt=10. Next edge -> o_alu_result=0x99999999, o_wb_addr=10, o_forwarded_data_A=0x12345678, o_forwarded_data_B=0x87654321.
- ADDI with shamt source: alu_src_A=1, shamt=3, alu_src_B=010, inm_ext_signed=0x0000ABCD, alu_opp=000, reg_dst=01, rd=15, src selects 01/01, wb_fwd=0x5B5B5B5B. Next edge -> result=0x0000ABD0, wb_addr=15, both forwarded outputs 0x5B5B5B5B.
- Shifts: SRA with bus_B=0x80000000 and A[4:0]=4 -> 0xF8000000. SLTU with 0xFFFFFFFF vs 1 -> 0. SLT with the same operands -> 1.
- Link: alu_opp=101, alu_src_B=100, next_seq_pc=0x00000008, reg_dst=00 -> result=0x00000008, wb_addr=31.
- Stall and overflow: load one result, then assert i_stall while changing inputs -> outputs unchanged. With EX_OVERFLOW_TRAP_EN, ADD of 0x7FFFFFFF+1 -> result 0x80000000 and o_overflow=1. Same operands with ADDU -> o_overflow=0.
